// File: rtl/aes_pkg.sv
// Shared constants and control-state encoding for the AES-128 decryption path.
package aes_pkg;

  localparam int unsigned  AES_LEN      = 128;
  localparam logic [127:0] KEY_ZERO_PAD = '0;
  localparam logic         ENCDEC_DEC   = 1'b1;
  localparam logic         KEYLEN_128   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_RD,
    ST_KEY_LD,
    ST_INIT,
    ST_INIT_WAIT,
    ST_NEXT,
    ST_NEXT_WAIT,
    ST_DONE
  } dec_state_e;

endpackage

// File: rtl/ROM_key.sv
// Key ROM with registered read: dout is valid the cycle after en.
module ROM_key #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (en) begin
      case (addr)
        ADDR_WIDTH'(0): dout <= DATA_WIDTH'(128'h000102030405060708090a0b0c0d0e0f);
        ADDR_WIDTH'(1): dout <= DATA_WIDTH'(128'h2b7e151628aed2a6abf7158809cf4f3c);
        default:        dout <= '0;
      endcase
    end
  end

endmodule

// File: rtl/aes_core.sv
// Iterative AES-128 decipher core: init expands the key (10 cycles), next deciphers one block (10 cycles).
module aes_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         encdec,
  input  logic         init,
  input  logic         next,
  output logic         ready,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [127:0] result,
  output logic         result_valid
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int unsigned i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns except in the last round
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic mix,
                                             input logic [127:0] rk);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        t[127-8*(c*4+r) -: 8] = isbox(s[127-8*(((c+4-r)%4)*4+r) -: 8]);
    t = t ^ rk;
    if (mix) begin
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        t[127-32*c -: 32] = {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                             gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                             gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                             gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
      end
    end
    return t;
  endfunction

  logic [127:0] rk_q [0:10];
  logic [127:0] kcur_q, st_q, kstep_d, round_d;
  logic [7:0]   rcon_q;
  logic [3:0]   cnt_q;
  logic         kexp_q, dec_q, ready_q, rv_q;
  logic         unused_cfg;

  // Decipher-only, 128-bit key in the upper half of the key bus
  assign unused_cfg   = ^{encdec, keylen, key[127:0]};
  assign kstep_d      = key_step(kcur_q, rcon_q);
  assign round_d      = inv_round(st_q, cnt_q != 4'd0, rk_q[cnt_q]);
  assign ready        = ready_q;
  assign result       = st_q;
  assign result_valid = rv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      kexp_q  <= 1'b0;
      dec_q   <= 1'b0;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
      kcur_q  <= '0;
      st_q    <= '0;
    end else if (kexp_q) begin
      kcur_q <= kstep_d;
      rcon_q <= xtime(rcon_q);
      if (cnt_q == 4'd10) begin
        kexp_q  <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end else if (dec_q) begin
      st_q <= round_d;
      if (cnt_q == 4'd0) begin
        dec_q   <= 1'b0;
        ready_q <= 1'b1;
        rv_q    <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else if (init) begin
      kexp_q  <= 1'b1;
      ready_q <= 1'b0;
      cnt_q   <= 4'd1;
      rcon_q  <= 8'h01;
      kcur_q  <= key[255:128];
    end else if (next) begin
      dec_q   <= 1'b1;
      ready_q <= 1'b0;
      rv_q    <= 1'b0;
      cnt_q   <= 4'd9;
      st_q    <= block ^ rk_q[10];
    end
  end

  always_ff @(posedge clk) begin
    if (kexp_q)
      rk_q[cnt_q] <= kstep_d;
    else if (!dec_q && init)
      rk_q[0] <= key[255:128];
  end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Decryption control FSM with one-entry expanded-key cache and ready guard cycle.
module aes_dec_ctrl import aes_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] key_addr_i,
  input  logic                  ready_i,
  input  logic                  result_valid_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  init_o,
  output logic                  next_o,
  output logic                  rom_en_o,
  output logic                  ld_ct_o,
  output logic                  ld_key_o,
  output logic                  ld_res_o,
  output logic                  done_o,
  output logic                  busy_o
);

  dec_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  key_vld_q, guard_q;
  logic                  init_q, next_q, rom_en_q, ld_key_q, done_q, busy_q;
  logic                  hit, res_ok;

  assign hit        = key_vld_q && (key_addr_i == addr_q);
  assign res_ok     = (state_q == ST_NEXT_WAIT) && !guard_q && ready_i && result_valid_i;
  // Capture strobes act on the deciding edge itself, so they decode state rather than register
  assign ld_ct_o    = (state_q == ST_IDLE) && start_i;
  assign ld_res_o   = res_ok;
  assign rom_addr_o = addr_q;
  assign init_o     = init_q;
  assign next_o     = next_q;
  assign rom_en_o   = rom_en_q;
  assign ld_key_o   = ld_key_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      key_vld_q <= 1'b0;
      guard_q   <= 1'b0;
      init_q    <= 1'b0;
      next_q    <= 1'b0;
      rom_en_q  <= 1'b0;
      ld_key_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      init_q   <= 1'b0;
      next_q   <= 1'b0;
      rom_en_q <= 1'b0;
      ld_key_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (hit) begin
              state_q <= ST_NEXT;
              next_q  <= 1'b1;
            end else begin
              addr_q    <= key_addr_i;
              key_vld_q <= 1'b0;
              state_q   <= ST_KEY_RD;
              rom_en_q  <= 1'b1;
            end
          end
        end
        ST_KEY_RD: begin
          state_q  <= ST_KEY_LD;
          ld_key_q <= 1'b1;
        end
        ST_KEY_LD: begin
          state_q <= ST_INIT;
          init_q  <= 1'b1;
        end
        ST_INIT: begin
          state_q <= ST_INIT_WAIT;
          guard_q <= 1'b1;
        end
        ST_INIT_WAIT: begin
          guard_q <= 1'b0;
          if (!guard_q && ready_i) begin
            key_vld_q <= 1'b1;
            state_q   <= ST_NEXT;
            next_q    <= 1'b1;
          end
        end
        ST_NEXT: begin
          state_q <= ST_NEXT_WAIT;
          guard_q <= 1'b1;
        end
        ST_NEXT_WAIT: begin
          guard_q <= 1'b0;
          if (res_ok) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_dec_top.sv
// AES-128 decryption top: key ROM fetch, cached key expansion and decipher on aes_core.
module aes_dec_top #(
  parameter int unsigned AES_LEN    = aes_pkg::AES_LEN,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] key_addr,
  input  logic [AES_LEN-1:0]    ciphertext,
  output logic [AES_LEN-1:0]    result,
  output logic                  done,
  output logic                  busy
);
  import aes_pkg::*;

  logic [AES_LEN-1:0]    ct_q, key_q, result_q, rom_dout, core_result;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  core_init, core_next, core_ready, core_rv;
  logic                  rom_en, ld_ct, ld_key, ld_res;

  aes_dec_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .key_addr_i     (key_addr),
    .ready_i        (core_ready),
    .result_valid_i (core_rv),
    .rom_addr_o     (rom_addr),
    .init_o         (core_init),
    .next_o         (core_next),
    .rom_en_o       (rom_en),
    .ld_ct_o        (ld_ct),
    .ld_key_o       (ld_key),
    .ld_res_o       (ld_res),
    .done_o         (done),
    .busy_o         (busy)
  );

  ROM_key #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(AES_LEN)) u_rom (
    .clk  (clk),
    .en   (rom_en),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  aes_core u_core (
    .clk          (clk),
    .reset_n      (~rst),
    .encdec       (ENCDEC_DEC),
    .init         (core_init),
    .next         (core_next),
    .ready        (core_ready),
    .key          ({key_q, KEY_ZERO_PAD}),
    .keylen       (KEYLEN_128),
    .block        (ct_q),
    .result       (core_result),
    .result_valid (core_rv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_q     <= '0;
      key_q    <= '0;
      result_q <= '0;
    end else begin
      if (ld_ct)  ct_q     <= ciphertext;
      if (ld_key) key_q    <= rom_dout;
      if (ld_res) result_q <= core_result;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_aes_dec_top.sv
// Directed checks of aes_dec_top: FIPS-197 vectors, key cache hit/miss, start handling, mid-run reset.
module tb_aes_dec_top;
  import aes_pkg::*;

  localparam int unsigned  T_DEC = 10;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   key_addr = '0;
  logic [127:0] ciphertext = '0;
  logic [127:0] result;
  logic         done, busy;

  int unsigned total = 0, bad = 0;
  int unsigned n_init = 0, n_next = 0, n_rom = 0, n_done = 0, n_overlap = 0, n_stray = 0;

  always #5 clk = ~clk;

  aes_dec_top #(.AES_LEN(128), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_addr   (key_addr),
    .ciphertext (ciphertext),
    .result     (result),
    .done       (done),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (dut.core_init) n_init++;
    if (dut.core_next) n_next++;
    if (dut.rom_en) n_rom++;
    if (done) n_done++;
    if (dut.core_init && dut.core_next) n_overlap++;
    if ((dut.core_init && dut.u_ctrl.state_q != ST_INIT) ||
        (dut.core_next && dut.u_ctrl.state_q != ST_NEXT)) n_stray++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input logic [4:0] a, input logic [127:0] ct, output int unsigned lat);
    @(negedge clk);
    key_addr   = a;
    ciphertext = ct;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    int unsigned lat, k, cyc, i0, n0, r0, d0;

    @(negedge clk);
    check("rst_result", result, '0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // FIPS-197 C.1, cold cache
    i0 = n_init; n0 = n_next; r0 = n_rom; d0 = n_done;
    run_block(5'd0, CT_A, lat);
    check("c1_result", result, PT_A);
    @(negedge clk);
    check("c1_done_pulse", done, 0);
    check("c1_idle_busy", busy, 0);
    check("c1_init", n_init - i0, 1);
    check("c1_next", n_next - n0, 1);
    check("c1_rom", n_rom - r0, 1);
    check("c1_dones", n_done - d0, 1);

    // same key_addr: cache hit
    i0 = n_init; n0 = n_next; r0 = n_rom;
    run_block(5'd0, CT_A, lat);
    check("hit_latency", lat, 3 + T_DEC);
    check("hit_result", result, PT_A);
    @(negedge clk);
    check("hit_rom", n_rom - r0, 0);
    check("hit_init", n_init - i0, 0);
    check("hit_next", n_next - n0, 1);

    // different key: miss, FIPS-197 appendix B vector
    i0 = n_init; r0 = n_rom;
    run_block(5'd1, CT_B, lat);
    check("miss_result", result, PT_B);
    @(negedge clk);
    check("miss_rom", n_rom - r0, 1);
    check("miss_init", n_init - i0, 1);

    // start held high for four blocks
    i0 = n_init; n0 = n_next; r0 = n_rom; d0 = n_done;
    @(negedge clk);
    key_addr = 5'd1; ciphertext = CT_B; start = 1'b1;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        k++;
        check("held_result", result, PT_B);
      end
    end
    start = 1'b0;
    check("held_blocks", k, 4);
    repeat (30) @(negedge clk);
    check("held_dones", n_done - d0, 4);
    check("held_next", n_next - n0, 4);
    check("held_init", n_init - i0, 0);
    check("held_rom", n_rom - r0, 0);
    check("held_busy", busy, 0);

    // inputs toggled while busy are ignored
    i0 = n_init; n0 = n_next; r0 = n_rom; d0 = n_done;
    @(negedge clk);
    key_addr = 5'd1; ciphertext = CT_B; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        start      = ~start;
        key_addr   = ~key_addr;
        ciphertext = ~ciphertext;
      end
    end while (!done && cyc < 200);
    start = 1'b0;
    check("tog_done_seen", done, 1);
    check("tog_result", result, PT_B);
    repeat (30) @(negedge clk);
    check("tog_dones", n_done - d0, 1);
    check("tog_next", n_next - n0, 1);
    check("tog_init", n_init - i0, 0);

    // reset during key expansion
    d0 = n_done;
    @(negedge clk);
    key_addr = 5'd0; ciphertext = CT_A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("iw_state", dut.u_ctrl.state_q, ST_INIT_WAIT);
    #1 rst = 1'b1;
    @(negedge clk);
    check("iw_rst_busy", busy, 0);
    check("iw_rst_done", done, 0);
    check("iw_rst_result", result, '0);
    rst = 1'b0;
    i0 = n_init; r0 = n_rom;
    run_block(5'd1, CT_B, lat);
    check("iw_after_result", result, PT_B);
    @(negedge clk);
    check("iw_after_rom", n_rom - r0, 1);
    check("iw_after_init", n_init - i0, 1);
    check("iw_dones", n_done - d0, 1);

    // reset during decipher on a cached key
    d0 = n_done;
    @(negedge clk);
    key_addr = 5'd1; ciphertext = CT_B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("nw_state", dut.u_ctrl.state_q, ST_NEXT_WAIT);
    #1 rst = 1'b1;
    @(negedge clk);
    check("nw_rst_busy", busy, 0);
    check("nw_rst_done", done, 0);
    check("nw_rst_result", result, '0);
    rst = 1'b0;
    i0 = n_init; r0 = n_rom;
    run_block(5'd1, CT_B, lat);
    check("nw_after_result", result, PT_B);
    @(negedge clk);
    check("nw_after_rom", n_rom - r0, 1);
    check("nw_after_init", n_init - i0, 1);
    check("nw_dones", n_done - d0, 1);

    check("init_next_overlap", n_overlap, 0);
    check("stray_init_next", n_stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
